// File: rtl/dsss_sync_decision.sv
// BPSK hard decision and serial-search lock detector (UNLOCK/VERIFY/LOCK) behind the DSSS correlator.
// Define DIFF_DECODE_EN for DBPSK differential decoding; the default build decodes coherent BPSK.
module dsss_sync_decision #(
  parameter int DUMP_ADDR   = 247,
  parameter int LOCK_HITS   = 3,
  parameter int LOSS_MISSES = 4,
  parameter int CW          = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    addr,
  input  logic [CW-1:0] corr,
  input  logic [CW-1:0] th,
  output logic          bit_out,
  output logic          bit_valid,
  output logic          lock,
  output logic          slip,
  output logic [CW-1:0] mag
);

  localparam int HW = $clog2(LOCK_HITS + 1);
  localparam int MW = $clog2(LOSS_MISSES + 1);
  localparam logic [7:0] DUMP = 8'(DUMP_ADDR);

  typedef enum logic [1:0] {UNLOCK, VERIFY, LOCKED} state_t;

  state_t        state_q, state_n;
  logic [HW-1:0] hit_cnt, hit_n;
  logic [MW-1:0] miss_cnt, miss_n;
  logic [7:0]    addr_d;
  logic          strobe, hit, slip_n, valid_n, decision;
  logic [CW-1:0] m;

  // One strobe per symbol, on the first cycle after addr leaves the dump address.
  assign strobe = (addr_d == DUMP) && (addr != DUMP);
  assign m      = corr[CW-1] ? (~corr + {{(CW-1){1'b0}}, 1'b1}) : corr;
  assign hit    = (m >= th);

`ifdef DIFF_DECODE_EN
  logic prev_sign;
  assign decision = corr[CW-1] ^ prev_sign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         prev_sign <= 1'b0;
    else if (strobe) prev_sign <= corr[CW-1];
  end
`else
  assign decision = ~corr[CW-1];
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state_q;
    hit_n   = hit_cnt;
    miss_n  = miss_cnt;
    slip_n  = 1'b0;
    valid_n = 1'b0;
    if (strobe) begin
      valid_n = (state_q == LOCKED);
      case (state_q)
        UNLOCK: begin
          if (hit) begin
            if (LOCK_HITS == 1) begin
              state_n = LOCKED;
              miss_n  = '0;
            end else begin
              state_n = VERIFY;
              hit_n   = HW'(1);
            end
          end else begin
            slip_n = 1'b1;
          end
        end
        VERIFY: begin
          if (hit) begin
            if (hit_cnt + 1'b1 == HW'(LOCK_HITS)) begin
              state_n = LOCKED;
              hit_n   = '0;
              miss_n  = '0;
            end else begin
              hit_n = hit_cnt + 1'b1;
            end
          end else begin
            state_n = UNLOCK;
            hit_n   = '0;
            slip_n  = 1'b1;
          end
        end
        LOCKED: begin
          if (hit) begin
            miss_n = '0;
          end else if (miss_cnt + 1'b1 == MW'(LOSS_MISSES)) begin
            state_n = UNLOCK;
            miss_n  = '0;
            hit_n   = '0;
            slip_n  = 1'b1;
          end else begin
            miss_n = miss_cnt + 1'b1;
          end
        end
        default: begin
          state_n = UNLOCK;
          hit_n   = '0;
          miss_n  = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= UNLOCK;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      addr_d    <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      lock      <= 1'b0;
      slip      <= 1'b0;
      mag       <= '0;
    end else begin
      state_q   <= state_n;
      hit_cnt   <= hit_n;
      miss_cnt  <= miss_n;
      addr_d    <= addr;
      bit_valid <= valid_n;
      slip      <= slip_n;
      lock      <= (state_n == LOCKED);
      if (strobe) begin
        mag     <= m;
        bit_out <= decision;
      end
    end
  end

endmodule

// File: tb/tb_dsss_sync_decision.sv
// Directed table-driven bench for dsss_sync_decision plus hand sequences for reset and dump-hold cases.
module tb_dsss_sync_decision;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic [22:0] corr, th;
  logic        bit_out, bit_valid, lock, slip;
  logic [22:0] mag;

  int checks = 0;
  int failures = 0;
  logic mprev = 1'b0;
  logic ebit;

  typedef struct {
    logic [22:0] corr;
    logic [22:0] th;
    logic        valid;
    logic        lock;
    logic        slip;
    logic [22:0] mag;
  } vec_t;

  vec_t tv[24];

  dsss_sync_decision dut (
    .clk(clk), .rst(rst), .addr(addr), .corr(corr), .th(th),
    .bit_out(bit_out), .bit_valid(bit_valid), .lock(lock), .slip(slip), .mag(mag)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one symbol ending in a strobe; outputs are sampled just after the registering edge.
  task automatic sym(input logic [22:0] c, input logic [22:0] t, input bit full);
    corr = c;
    th   = t;
    if (full) begin
      for (int a = 0; a < 247; a++) begin
        addr = 8'(a);
        step();
      end
    end
    addr = 8'd247;
    step();
    addr = 8'd0;
`ifdef DIFF_DECODE_EN
    ebit = c[22] ^ mprev;
`else
    ebit = ~c[22];
`endif
    mprev = c[22];
    step();
  endtask

  function automatic vec_t mk(input logic [22:0] c, input logic [22:0] t,
                              input logic v, input logic l, input logic s, input logic [22:0] m);
    vec_t r;
    r.corr = c; r.th = t; r.valid = v; r.lock = l; r.slip = s; r.mag = m;
    return r;
  endfunction

  initial begin
    int cnt;
    tv[0]  = mk(23'd5000, 23'd1000, 0, 0, 0, 23'd5000);
    tv[1]  = mk(23'd5000, 23'd1000, 0, 0, 0, 23'd5000);
    tv[2]  = mk(23'd5000, 23'd1000, 0, 1, 0, 23'd5000);
    tv[3]  = mk(23'd5000, 23'd1000, 1, 1, 0, 23'd5000);
    tv[4]  = mk(23'd20,   23'd1000, 1, 1, 0, 23'd20);
    tv[5]  = mk(23'd20,   23'd1000, 1, 1, 0, 23'd20);
    tv[6]  = mk(23'd20,   23'd1000, 1, 1, 0, 23'd20);
    tv[7]  = mk(23'd5000, 23'd1000, 1, 1, 0, 23'd5000);
    tv[8]  = mk(23'd20,   23'd1000, 1, 1, 0, 23'd20);
    tv[9]  = mk(23'd20,   23'd1000, 1, 1, 0, 23'd20);
    tv[10] = mk(23'd20,   23'd1000, 1, 1, 0, 23'd20);
    tv[11] = mk(23'd20,   23'd1000, 1, 0, 1, 23'd20);
    tv[12] = mk(23'h400000, 23'd4194304, 0, 0, 0, 23'd4194304);
    tv[13] = mk(23'h400000, 23'd4194304, 0, 0, 0, 23'd4194304);
    tv[14] = mk(23'h400000, 23'd4194304, 0, 1, 0, 23'd4194304);
    tv[15] = mk(23'h400000, 23'd4194304, 1, 1, 0, 23'd4194304);
    tv[16] = mk(23'd5000, 23'd1000, 1, 1, 0, 23'd5000);
    tv[17] = mk(23'h400000, 23'd4194304, 1, 1, 0, 23'd4194304);
    tv[18] = mk(23'd0,    23'd0,    1, 1, 0, 23'd0);
    tv[19] = mk(-23'sd20, 23'd1000, 1, 1, 0, 23'd20);
    tv[20] = mk(-23'sd20, 23'd1000, 1, 1, 0, 23'd20);
    tv[21] = mk(-23'sd20, 23'd1000, 1, 1, 0, 23'd20);
    tv[22] = mk(-23'sd20, 23'd1000, 1, 0, 1, 23'd20);
    tv[23] = mk(-23'sd20, 23'd1000, 0, 0, 1, 23'd20);

    rst = 1'b1; addr = 8'd0; corr = '0; th = 23'd100;
    repeat (3) step();
    check("reset_bit_out", bit_out, 0);
    check("reset_bit_valid", bit_valid, 0);
    check("reset_lock", lock, 0);
    check("reset_slip", slip, 0);
    check("reset_mag", mag, 0);
    rst = 1'b0;

    // Full address sweeps with zero correlation: searching, one slip per symbol.
    for (int s = 0; s < 3; s++) begin
      sym(23'd0, 23'd100, 1'b1);
      check("search_slip", slip, 1);
      check("search_valid", bit_valid, 0);
      check("search_lock", lock, 0);
      check("search_mag", mag, 0);
      step();
      check("search_slip_width", slip, 0);
    end

    for (int i = 0; i < 24; i++) begin
      sym(tv[i].corr, tv[i].th, 1'b0);
      check($sformatf("vec%0d_valid", i), bit_valid, tv[i].valid);
      check($sformatf("vec%0d_lock", i), lock, tv[i].lock);
      check($sformatf("vec%0d_slip", i), slip, tv[i].slip);
      check($sformatf("vec%0d_mag", i), mag, tv[i].mag);
      check($sformatf("vec%0d_bit", i), bit_out, ebit);
      step();
      check($sformatf("vec%0d_pulse_width", i), {30'd0, bit_valid, slip}, 0);
    end

    // Two hits then a miss drops VERIFY back to UNLOCK with a slip.
    sym(23'd5000, 23'd1000, 1'b0);
    sym(23'd5000, 23'd1000, 1'b0);
    sym(23'd20, 23'd1000, 1'b0);
    check("verify_miss_slip", slip, 1);
    check("verify_miss_lock", lock, 0);

    // Asynchronous reset in VERIFY, then restart from UNLOCK.
    sym(23'd5000, 23'd1000, 1'b0);
    sym(23'd5000, 23'd1000, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("async_rst_mag", mag, 0);
    check("async_rst_bit", bit_out, 0);
    check("async_rst_lock", lock, 0);
    mprev = 1'b0;
    step();
    rst = 1'b0;
    sym(23'd5000, 23'd1000, 1'b0);
    check("post_rst_hit1_lock", lock, 0);
    sym(23'd5000, 23'd1000, 1'b0);
    check("post_rst_hit2_lock", lock, 0);
    sym(23'd5000, 23'd1000, 1'b0);
    check("post_rst_hit3_lock", lock, 1);

    // addr held at the dump address: exactly one evaluation after it leaves.
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      addr = 8'd247;
      step();
      cnt += int'(bit_valid) + int'(slip);
    end
    addr = 8'd0;
    step();
    check("hold_valid_after_leave", bit_valid, 1);
    cnt += int'(bit_valid) + int'(slip);
    for (int k = 0; k < 5; k++) begin
      step();
      cnt += int'(bit_valid) + int'(slip);
    end
    check("hold_single_pulse", cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsss_sync_decision.md
Name: dsss_sync_decision

Overview:
- Downstream stage of the DSSS despreading correlator.
- Consumes the 23-bit per-symbol correlation value and the PN chip address.
- Makes the BPSK hard bit decision and runs a serial-search lock detector (UNLOCK/VERIFY/LOCK).
- Issues one-chip slip requests back to the PN generator until code phase is acquired.

Parameters:
- DUMP_ADDR, 247: PN address at which the correlator dumps; its output is stable once addr leaves this value.
- LOCK_HITS, 3: consecutive threshold hits needed to enter LOCK (UNLOCK hit counts as hit 1).
- LOSS_MISSES, 4: consecutive misses in LOCK before declaring loss of lock.
- CW, 23: correlation width in bits.

Ports:
- clk  in  1  FPGA system clock (49.6 MHz).
- rst  in  1  asynchronous active-high reset.
- addr  in  8  PN chip address, same counter that drives the correlator.
- corr  in  CW  signed correlation from the correlator, held between dumps.
- th  in  CW  unsigned lock threshold on |corr|, sampled at each strobe.
- bit_out  out  1  decided data bit.
- bit_valid  out  1  one-cycle pulse, bit_out valid.
- lock  out  1  high while in LOCK.
- slip  out  1  one-cycle pulse: PN generator delays code phase by one chip.
- mag  out  CW  |corr| of the last evaluated symbol, unsigned.

Behaviour:
- Reset (async, rst=1) clears everything:
  - bit_out=0, bit_valid=0, lock=0, slip=0, mag=0.
  - state=UNLOCK, hit_cnt=0, miss_cnt=0, addr_d=0, prev_sign=0.
- Strobe:
  - addr_d registers addr every clk.
  - strobe = (addr_d==DUMP_ADDR) && (addr!=DUMP_ADDR), i.e. exactly one cycle per symbol.
  - addr held at DUMP_ADDR for several cycles gives a single strobe after it leaves.
- Magnitude: m = corr[CW-1] ? -corr : corr, computed in CW-bit unsigned. corr=-2^(CW-1) gives m=2^(CW-1) with no overflow.
- Hit/miss: hit = (m >= th), unsigned compare. th=0 makes every symbol a hit.
- Registered updates on the strobe edge; outputs change the clock after the strobe cycle (latency 1):
  - mag <= m.
  - bit_out <= decision (see Optional Feature).
  - prev_sign <= corr[CW-1].
  - bit_valid pulses iff the state before the update was LOCK. Flywheel misses in LOCK still emit bits; the symbol that causes entry into LOCK does not.
- State machine, evaluated only on strobe:
  - UNLOCK:
    - hit -> VERIFY, hit_cnt=1.
    - miss -> stay, slip pulse.
  - VERIFY:
    - hit -> hit_cnt+1; when it reaches LOCK_HITS -> LOCK, miss_cnt=0.
    - miss -> UNLOCK, hit_cnt=0, slip pulse.
  - LOCK:
    - hit -> miss_cnt=0.
    - miss -> miss_cnt+1; when it reaches LOSS_MISSES -> UNLOCK, hit_cnt=0, slip pulse.
  - LOCK_HITS=1 goes UNLOCK->LOCK directly on the first hit.
- Pulse widths: slip and bit_valid are one clk wide and 0 on all non-strobe cycles. lock = (state==LOCK), registered.
- Counters are sized for their parameter max and never wrap; both reset to 0 on every state exit.
- Reset mid-symbol or mid-VERIFY: immediate return to the reset state; the next strobe is evaluated from UNLOCK.

Optional Feature:
- Macro: DIFF_DECODE_EN.
- Defined: DBPSK differential decode, bit_out = corr[CW-1] XOR prev_sign, i.e. 1 on a phase change. prev_sign tracks every strobe regardless of lock.
- Undefined: coherent BPSK, bit_out = ~corr[CW-1], so corr>=0 gives 1. prev_sign is unused and may be removed.

Test Plan:
- Reset then addr cycling 0..247 with corr=0 and th=100 -> one slip pulse per symbol, lock=0, bit_valid never asserted, mag=0.
- th=1000; corr=+5000 for 4 symbols -> lock rises after symbol 3; symbol 4 gives bit_valid=1, bit_out=1 (coherent), mag=5000.
- In LOCK, corr=+20 for 3 symbols then +5000 -> lock stays 1, 4 bit_valid pulses, no slip. Then 4 symbols of +20 -> lock falls with a slip on the 4th.
- corr=-4194304, th=4194304 -> mag=4194304, counts as a hit; in LOCK, bit_out=0 (coherent), or with DIFF_DECODE_EN and prev corr positive, bit_out=1.
- VERIFY after 2 hits, then one miss -> UNLOCK plus slip; rst asserted during VERIFY -> all outputs 0 asynchronously.
- addr held at 247 for 5 cycles, then 0 -> exactly one strobe evaluation: a single bit_valid or slip pulse one clk after addr leaves 247.
